md_seq: RTL

MD_SEQ -- requirements
Module: md_seq

---
 rtl/md_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/md_seq.sv
// HI/LO multiply-divide sequencer: 32-step radix-2 MULT/MULTU/DIV/DIVU, plus MTHI/MTLO moves.
// Latency: start at edge N -> HI/LO valid after edge N+34 (MULT/MULTU after N+3 with MD_FAST_MUL_EN).
// Backpressure: while busy, start/mthi/mtlo/hilo_rd raise stall and are ignored until idle.
module md_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        hilo_rd,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        dz
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_fix_ph;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_dz;

    logic        w_is_div;
    logic        w_signed;
    logic        w_go;
    logic        w_calc_done;
    logic        w_fast;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic [63:0] w_div_step;
    logic [63:0] w_calc_nxt;
    logic        w_neg_q;
    logic        w_neg_r;
    logic [63:0] w_fix;
    logic        w_div_zero;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_go     = start & ~flush;
    assign w_abs_a  = (!md_op[0] && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_abs_b  = (!md_op[0] && src_b[31]) ? (32'd0 - src_b) : src_b;

`ifdef MD_FAST_MUL_EN
    assign w_fast = ~w_is_div;
`else
    assign w_fast = 1'b0;
`endif

    assign w_calc_done = (r_cnt == 5'd31) | w_fast;

    // Multiply: accumulate into the upper half, shift the multiplier out of the lower half.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc[31:1]};

    // Divide: upper half is the remainder, lower half shifts dividend out and quotient in.
    assign w_rem_sh   = r_acc[63:31];
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_div_step = w_diff[33] ? {r_acc[62:0], 1'b0}
                                   : {w_diff[31:0], r_acc[30:0], 1'b1};

    always_comb begin
        w_calc_nxt = w_is_div ? w_div_step : w_mul_step;
`ifdef MD_FAST_MUL_EN
        if (w_fast) begin
            w_calc_nxt = {32'd0, r_acc[31:0]} * {32'd0, r_b};
        end
`endif
    end

    assign w_neg_q    = w_signed & (r_sign_a ^ r_sign_b);
    assign w_neg_r    = w_signed & r_sign_a;
    assign w_fix      = w_is_div ? {(w_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32]),
                                    (w_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0])}
                                 : (w_neg_q ? (64'd0 - r_acc) : r_acc);
    assign w_div_zero = w_is_div & (r_b == 32'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_CALC;
            S_CALC:  if (flush) w_state_nxt = S_IDLE;
                     else if (w_calc_done) w_state_nxt = S_FIX;
            S_FIX:   if (flush || r_fix_ph) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_fix_ph <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_dz     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dz    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_op     <= md_op;
                        r_sign_a <= src_a[31];
                        r_sign_b <= src_b[31];
                        r_acc    <= {32'd0, w_abs_a};
                        r_b      <= w_abs_b;
                        r_cnt    <= 5'd0;
                        r_fix_ph <= 1'b0;
                    end else if (!start) begin
                        if (mthi) r_hi <= src_a;
                        if (mtlo) r_lo <= src_a;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= w_calc_nxt;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FIX: begin
                    // Sign fix is registered first; HI/LO commit on the second FIX cycle.
                    if (!flush) begin
                        if (!r_fix_ph) begin
                            r_acc    <= w_fix;
                            r_fix_ph <= 1'b1;
                        end else if (w_div_zero) begin
                            r_dz <= 1'b1;
                        end else begin
                            r_hi <= r_acc[63:32];
                            r_lo <= r_acc[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | mthi | mtlo | hilo_rd);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign dz    = r_dz;

endmodule
